// File: rtl/ifm_window_reader_u1_s28_k5_pkg.sv
// Shared sizing, kernel step table and FSM encoding for the 5x5 IFM window reader.
package ifm_window_reader_u1_s28_k5_pkg;

   localparam int DATA_WIDTH       = 32;
   localparam int IFM_SIZE         = 28;
   localparam int KERNEL_SIZE      = 5;
   localparam int OFM_SIZE         = IFM_SIZE - KERNEL_SIZE + 1;
   localparam int KERNEL_ELEMS     = KERNEL_SIZE * KERNEL_SIZE;
   localparam int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE);
   localparam int K_W              = $clog2(KERNEL_ELEMS + 1);
   localparam int RC_W             = $clog2(OFM_SIZE);

   localparam logic [K_W-1:0]  K_LAST  = K_W'(KERNEL_ELEMS - 1);
   localparam logic [RC_W-1:0] RC_LAST = RC_W'(OFM_SIZE - 1);

   // Bit k is set where k%5 == 4, i.e. the next element starts a new kernel row.
   localparam logic [31:0] KX_LAST_MASK = 32'h0108_4210;

   localparam logic [ADDRESS_SIZE_IFM-1:0] STEP_COL = ADDRESS_SIZE_IFM'(1);
   localparam logic [ADDRESS_SIZE_IFM-1:0] STEP_ROW = ADDRESS_SIZE_IFM'(IFM_SIZE - KERNEL_SIZE + 1);
   localparam logic [ADDRESS_SIZE_IFM-1:0] STEP_WIN_ROW = ADDRESS_SIZE_IFM'(IFM_SIZE - OFM_SIZE + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWAP  = 2'd1,
      ST_READ  = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   // Address delta from window element k to element k+1.
   function automatic logic [ADDRESS_SIZE_IFM-1:0] elem_step(input logic [K_W-1:0] k);
      return KX_LAST_MASK[k] ? STEP_ROW : STEP_COL;
   endfunction

endpackage

// File: rtl/ifm_window_reader_u1_s28_k5_window_addr_gen.sv
// Window walk counters (r, c, k) and incremental port A/B address generation.
module ifm_window_reader_u1_s28_k5_window_addr_gen
   import ifm_window_reader_u1_s28_k5_pkg::*;
(
   input  logic                        clk_sys,
   input  logic                        rst_b,
   input  logic                        clear,
   input  logic                        advance,
   output logic [ADDRESS_SIZE_IFM-1:0] addr_a,
   output logic [ADDRESS_SIZE_IFM-1:0] addr_b,
   output logic                        k_last,
   output logic                        frame_last
);

   logic [RC_W-1:0]             r;
   logic [RC_W-1:0]             c;
   logic [K_W-1:0]              k;
   logic [ADDRESS_SIZE_IFM-1:0] base;
   logic [ADDRESS_SIZE_IFM-1:0] ofs_a;
   logic [ADDRESS_SIZE_IFM-1:0] ofs_b;

   assign ofs_b      = ofs_a + elem_step(k);
   assign addr_a     = base + ofs_a;
   assign addr_b     = base + ofs_b;
   assign k_last     = (k == K_LAST);
   assign frame_last = k_last && (r == RC_LAST) && (c == RC_LAST);

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         r     <= '0;
         c     <= '0;
         k     <= '0;
         base  <= '0;
         ofs_a <= '0;
      end else if (clear) begin
         r     <= '0;
         c     <= '0;
         k     <= '0;
         base  <= '0;
         ofs_a <= '0;
      end else if (advance) begin
         if (k_last) begin
            k     <= '0;
            ofs_a <= '0;
            if (c == RC_LAST) begin
               c    <= '0;
               r    <= r + RC_W'(1);
               base <= base + STEP_WIN_ROW;
            end else begin
               c    <= c + RC_W'(1);
               base <= base + STEP_COL;
            end
         end else begin
            k     <= k + K_W'(2);
            ofs_a <= ofs_b + elem_step(k + K_W'(1));
         end
      end
   end

endmodule

// File: rtl/ifm_window_reader_u1_s28_k5.sv
// IFM ping-pong consumer: bank swap control, 5x5 window read issue and MAC-side pixel pipeline.
//
// state    | meaning
// ST_IDLE  | waiting for a committed frame (pending or frame_written)
// ST_SWAP  | toggle ifm_sel, clear pending, zero walk counters
// ST_READ  | issue one A/B read pair per non-paused cycle
// ST_FLUSH | last pair returning; pulse done
module ifm_window_reader_u1_s28_k5
   import ifm_window_reader_u1_s28_k5_pkg::*;
(
   input  logic                        clk_sys,
   input  logic                        rst_b,
   input  logic                        frame_written,
   output logic                        prev_ready,
   input  logic                        pause,
   output logic                        ifm_sel,
   output logic                        ifm_enable_read_A_next,
   output logic                        ifm_enable_read_B_next,
   output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_A_next,
   output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_B_next,
   input  logic [DATA_WIDTH-1:0]       data_out_A_for_next1,
   input  logic [DATA_WIDTH-1:0]       data_out_B_for_next1,
   output logic [DATA_WIDTH-1:0]       win_data_A,
   output logic [DATA_WIDTH-1:0]       win_data_B,
   output logic                        win_valid_A,
   output logic                        win_valid_B,
   output logic                        win_last,
   output logic                        busy,
   output logic                        done
);

   state_t                      state;
   state_t                      state_n;
   logic                        pending;
   logic                        issue;
   logic                        en_b;
   logic                        counters_clear;
   logic                        k_last;
   logic                        frame_last;
   logic [ADDRESS_SIZE_IFM-1:0] addr_a;
   logic [ADDRESS_SIZE_IFM-1:0] addr_b;

   ifm_window_reader_u1_s28_k5_window_addr_gen u_addr_gen (
      .clk_sys    (clk_sys),
      .rst_b      (rst_b),
      .clear      (counters_clear),
      .advance    (issue),
      .addr_a     (addr_a),
      .addr_b     (addr_b),
      .k_last     (k_last),
      .frame_last (frame_last)
   );

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n        = state;
      issue          = 1'b0;
      en_b           = 1'b0;
      counters_clear = 1'b0;
      busy           = 1'b1;
      done           = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (pending || frame_written) state_n = ST_SWAP;
         end
         ST_SWAP: begin
            counters_clear = 1'b1;
            state_n        = ST_READ;
         end
         ST_READ: begin
            issue = !pause;
            en_b  = !pause && !k_last;
            if (issue && frame_last) state_n = ST_FLUSH;
         end
         ST_FLUSH: begin
            done    = 1'b1;
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         pending     <= 1'b0;
         ifm_sel     <= 1'b0;
         win_valid_A <= 1'b0;
         win_valid_B <= 1'b0;
         win_last    <= 1'b0;
      end else begin
         pending     <= (state == ST_SWAP) ? 1'b0 : (pending | frame_written);
         if (state == ST_SWAP) ifm_sel <= ~ifm_sel;
         win_valid_A <= issue;
         win_valid_B <= en_b;
         win_last    <= issue && k_last;
      end
   end

   // Bank addresses are ORed in the memory array, so idle ports must drive zero.
   assign ifm_enable_read_A_next  = issue;
   assign ifm_enable_read_B_next  = en_b;
   assign ifm_address_read_A_next = issue ? addr_a : '0;
   assign ifm_address_read_B_next = en_b ? addr_b : '0;

   assign win_data_A = win_valid_A ? data_out_A_for_next1 : '0;
   assign win_data_B = win_valid_B ? data_out_B_for_next1 : '0;
   assign prev_ready = ~pending;

endmodule
